control_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit enkel datapath. Fetches two-byte instructions from a 256-byte asynchronous-read memory, holds the program counter and instruction register, and drives every load, select, enable and reset strobe of the ALU block. Sits directly upstream of the ALU: its control outputs feed the ALU's control inputs, and its `from_IR` output feeds the ALU's immediate path.

---
 rtl/enkel_pkg.sv | 38 +++
 rtl/program_counter.sv | 37 +++
 rtl/control_sequencer.sv | 141 ++++++++++++++
 tb/tb_control_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enkel_pkg.sv
// Shared definitions for the enkel control path: word width, opcodes, FSM states.
package enkel_pkg;

  localparam int unsigned WORD_W = 8;

  localparam logic [WORD_W-1:0] OP_NOP = 8'h00;
  localparam logic [WORD_W-1:0] OP_LDA = 8'h01;
  localparam logic [WORD_W-1:0] OP_LDI = 8'h02;
  localparam logic [WORD_W-1:0] OP_ADD = 8'h03;
  localparam logic [WORD_W-1:0] OP_ADI = 8'h04;
  localparam logic [WORD_W-1:0] OP_NTM = 8'h05;
  localparam logic [WORD_W-1:0] OP_STA = 8'h06;
  localparam logic [WORD_W-1:0] OP_JMP = 8'h07;
  localparam logic [WORD_W-1:0] OP_JC  = 8'h08;
  localparam logic [WORD_W-1:0] OP_HLT = 8'hFF;

  typedef enum logic [2:0] {
    ST_FETCH_OP,
    ST_FETCH_ARG,
    ST_LOAD_B,
    ST_LATCH,
    ST_WRITE_A,
    ST_STORE,
    ST_HALT
  } state_e;

  // Opcodes that run the LOAD_B / LATCH / WRITE_A sequence.
  function automatic logic is_alu_op(input logic [WORD_W-1:0] op);
    return (op == OP_LDA) || (op == OP_LDI) || (op == OP_ADD) ||
           (op == OP_ADI) || (op == OP_NTM);
  endfunction

  // ALU opcodes whose B operand comes from memory rather than the IR.
  function automatic logic is_mem_src(input logic [WORD_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_NTM);
  endfunction

endpackage

// File: rtl/program_counter.sv
// 8-bit program counter: load has priority over increment, async clear.
module program_counter
  import enkel_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_val_i,
  output logic [WORD_W-1:0] pc_o
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;

  // Next PC: jump target overrides the sequential increment (wraps FF->00).
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + WORD_W'(1);
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode sequencer driving the enkel ALU control strobes.
module control_sequencer
  import enkel_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              carry,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] from_IR,
  output logic [WORD_W-1:0] from_PC,
  output logic              Aload,
  output logic              Bload,
  output logic              latch_A_load,
  output logic              Areset,
  output logic              Breset,
  output logic              A_PC_select,
  output logic              MEM_IR_select,
  output logic              compliment_or_adder,
  output logic              A_PC_enable,
  output logic              mem_IR_enable,
  output logic              adder_compliment_enable,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_op_q, ir_op_d;
  logic [WORD_W-1:0] ir_arg_q, ir_arg_d;
  logic [WORD_W-1:0] pc;
  logic              pc_inc;
  logic              pc_load;
  logic              areset_dec;

  program_counter u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (mem_data),
    .pc_o       (pc)
  );

  // State and instruction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH_OP;
      ir_op_q  <= '0;
      ir_arg_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_op_q  <= ir_op_d;
      ir_arg_q <= ir_arg_d;
    end
  end

  // Next state, IR capture and PC control; the jump target is the operand byte being fetched.
  always_comb begin
    state_d  = state_q;
    ir_op_d  = ir_op_q;
    ir_arg_d = ir_arg_q;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    case (state_q)
      ST_FETCH_OP: begin
        ir_op_d = mem_data;
        pc_inc  = 1'b1;
        state_d = ST_FETCH_ARG;
      end
      ST_FETCH_ARG: begin
        ir_arg_d = mem_data;
        pc_inc   = 1'b1;
        if (is_alu_op(ir_op_q)) begin
          state_d = ST_LOAD_B;
        end else if (ir_op_q == OP_STA) begin
          state_d = ST_STORE;
        end else if (ir_op_q == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          pc_load = (ir_op_q == OP_JMP) || ((ir_op_q == OP_JC) && carry);
          state_d = ST_FETCH_OP;
        end
      end
      ST_LOAD_B:  state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_WRITE_A;
      ST_WRITE_A: state_d = ST_FETCH_OP;
      ST_STORE:   state_d = ST_FETCH_OP;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH_OP;
    endcase
  end

  // Moore strobe decode from (state, opcode).
  always_comb begin
    mem_addr                = pc;
    mem_we                  = 1'b0;
    Aload                   = 1'b0;
    Bload                   = 1'b0;
    latch_A_load            = 1'b0;
    areset_dec              = 1'b0;
    A_PC_select             = 1'b0;
    MEM_IR_select           = 1'b0;
    compliment_or_adder     = 1'b0;
    A_PC_enable             = 1'b0;
    mem_IR_enable           = 1'b0;
    adder_compliment_enable = 1'b0;
    halted                  = 1'b0;
    case (state_q)
      ST_LOAD_B: begin
        Bload         = 1'b1;
        mem_IR_enable = 1'b1;
        if (is_mem_src(ir_op_q)) begin
          MEM_IR_select = 1'b1;
          mem_addr      = ir_arg_q;
        end
        areset_dec = (ir_op_q == OP_LDA) || (ir_op_q == OP_LDI);
      end
      ST_LATCH: begin
        latch_A_load            = 1'b1;
        adder_compliment_enable = 1'b1;
        A_PC_enable             = 1'b1;
        A_PC_select             = 1'b1;
        compliment_or_adder     = (ir_op_q == OP_NTM);
      end
      ST_WRITE_A: Aload = 1'b1;
      ST_STORE: begin
        mem_addr = ir_arg_q;
        mem_we   = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // ALU clears follow reset_n combinationally so the ALU empties in the same cycles.
  assign Areset  = ~reset_n | areset_dec;
  assign Breset  = ~reset_n;
  assign from_IR = ir_arg_q;
  assign from_PC = pc;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model plus random programs.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       carry = 1'b0;
  logic [7:0] mem_data;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] from_IR;
  logic [7:0] from_PC;
  logic       Aload, Bload, latch_A_load, Areset, Breset;
  logic       A_PC_select, MEM_IR_select, compliment_or_adder;
  logic       A_PC_enable, mem_IR_enable, adder_compliment_enable, halted;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  control_sequencer dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .mem_data                (mem_data),
    .carry                   (carry),
    .mem_addr                (mem_addr),
    .mem_we                  (mem_we),
    .from_IR                 (from_IR),
    .from_PC                 (from_PC),
    .Aload                   (Aload),
    .Bload                   (Bload),
    .latch_A_load            (latch_A_load),
    .Areset                  (Areset),
    .Breset                  (Breset),
    .A_PC_select             (A_PC_select),
    .MEM_IR_select           (MEM_IR_select),
    .compliment_or_adder     (compliment_or_adder),
    .A_PC_enable             (A_PC_enable),
    .mem_IR_enable           (mem_IR_enable),
    .adder_compliment_enable (adder_compliment_enable),
    .halted                  (halted)
  );

  // Strobe vector bit positions.
  localparam logic [12:0] S_ALOAD = 13'h1000;
  localparam logic [12:0] S_BLOAD = 13'h0800;
  localparam logic [12:0] S_LTCH  = 13'h0400;
  localparam logic [12:0] S_ARST  = 13'h0200;
  localparam logic [12:0] S_BRST  = 13'h0100;
  localparam logic [12:0] S_APSEL = 13'h0080;
  localparam logic [12:0] S_MSEL  = 13'h0040;
  localparam logic [12:0] S_CMP   = 13'h0020;
  localparam logic [12:0] S_APEN  = 13'h0010;
  localparam logic [12:0] S_MIEN  = 13'h0008;
  localparam logic [12:0] S_ACEN  = 13'h0004;
  localparam logic [12:0] S_WE    = 13'h0002;
  localparam logic [12:0] S_HALT  = 13'h0001;
  localparam logic [12:0] S_LATCH = S_LTCH | S_ACEN | S_APEN | S_APSEL;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned we_cnt   = 0;

  // Reference architectural state.
  logic [7:0] pc_m;
  logic [7:0] a_m;
  logic       c_m;
  bit         halted_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] strobes();
    return {Aload, Bload, latch_A_load, Areset, Breset, A_PC_select, MEM_IR_select,
            compliment_or_adder, A_PC_enable, mem_IR_enable, adder_compliment_enable,
            mem_we, halted};
  endfunction

  task automatic check_outs(input string tag, input logic [7:0] ea, input logic [12:0] es,
                            input logic [7:0] epc);
    check_eq({tag, ".addr"}, 32'(mem_addr), 32'(ea));
    check_eq({tag, ".strobes"}, 32'(strobes()), 32'(es));
    check_eq({tag, ".pc"}, 32'(from_PC), 32'(epc));
  endtask

  // Check one cycle then advance to the next negedge, applying memory write / carry update at the edge.
  task automatic step(input string tag, input logic [7:0] ea, input logic [12:0] es,
                      input logic [7:0] epc, input bit do_wr, input logic [7:0] wa,
                      input logic [7:0] wd, input bit upd_c, input logic nc);
    check_outs(tag, ea, es, epc);
    if (mem_we) we_cnt++;
    @(posedge clk);
    if (do_wr) mem[wa] = wd;
    if (upd_c) carry = nc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    carry   = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_outs("reset", 8'h00, S_ARST | S_BRST, 8'h00);
      check_eq("reset.ir", 32'(from_IR), 32'h0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    #1;
    pc_m = 8'h00; a_m = 8'h00; c_m = 1'b0; halted_m = 1'b0;
  endtask

  // Execute one instruction at the ISA level and check every cycle it should take.
  task automatic exec_instr();
    logic [7:0] p, p1, p2, op, arg, opnd;
    logic [8:0] sum;
    logic [12:0] es;
    bit mem_src;
    p  = pc_m;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    op = mem[p];
    step("fetch_op", p, 13'h0, p, 0, 8'h0, 8'h0, 0, 1'b0);
    arg = mem[p1];
    step("fetch_arg", p1, 13'h0, p1, 0, 8'h0, 8'h0, 0, 1'b0);
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h05: begin
        mem_src = (op == 8'h01) || (op == 8'h03) || (op == 8'h05);
        opnd = mem_src ? mem[arg] : arg;
        es = S_BLOAD | S_MIEN | (mem_src ? S_MSEL : 13'h0) |
             (((op == 8'h01) || (op == 8'h02)) ? S_ARST : 13'h0);
        check_eq("load_b.from_ir", 32'(from_IR), 32'(arg));
        step("load_b", mem_src ? arg : p2, es, p2, 0, 8'h0, 8'h0, 0, 1'b0);
        case (op)
          8'h03, 8'h04: begin
            sum = {1'b0, a_m} + {1'b0, opnd};
            a_m = sum[7:0];
            c_m = sum[8];
          end
          8'h05:   begin a_m = ~opnd; c_m = 1'b0; end
          default: begin a_m = opnd;  c_m = 1'b0; end
        endcase
        step("latch", p2, S_LATCH | ((op == 8'h05) ? S_CMP : 13'h0), p2, 0, 8'h0, 8'h0, 1, c_m);
        step("write_a", p2, S_ALOAD, p2, 0, 8'h0, 8'h0, 0, 1'b0);
        pc_m = p2;
      end
      8'h06: begin
        step("store", arg, S_WE, p2, 1, arg, a_m, 0, 1'b0);
        pc_m = p2;
      end
      8'h07: pc_m = arg;
      8'h08: pc_m = c_m ? arg : p2;
      8'hFF: begin pc_m = p2; halted_m = 1'b1; end
      default: pc_m = p2;
    endcase
  endtask

  // Run n instructions; a halt is held for a few cycles and then cleared by reset.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      exec_instr();
      if (halted_m) begin
        for (int k = 0; k < 3; k++) step("halt", pc_m, S_HALT, pc_m, 0, 8'h0, 8'h0, 0, 1'b0);
        do_reset();
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    logic [7:0] optab [10];
    optab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    clear_mem();
    @(negedge clk);
    do_reset();

    // LDI 05; ADI 03; HLT -> halted after 12 cycles with PC=06.
    mem[0] = 8'h02; mem[1] = 8'h05; mem[2] = 8'h04; mem[3] = 8'h03; mem[4] = 8'hFF;
    run(3);

    // LDA/ADD/STA: exactly one write pulse at address 12.
    clear_mem();
    mem[0] = 8'h01; mem[1] = 8'h10; mem[2] = 8'h03; mem[3] = 8'h11;
    mem[4] = 8'h06; mem[5] = 8'h12; mem[6] = 8'hFF;
    mem[8'h10] = 8'hF0; mem[8'h11] = 8'h20;
    we_cnt = 0;
    run(4);
    check_eq("sta.we_pulses", 32'(we_cnt), 32'd1);

    // JC taken (carry=1).
    clear_mem();
    mem[0] = 8'h02; mem[1] = 8'hFF; mem[2] = 8'h04; mem[3] = 8'h01;
    mem[4] = 8'h08; mem[5] = 8'h20; mem[8'h20] = 8'hFF;
    run(4);

    // JC not taken (carry=0).
    clear_mem();
    mem[0] = 8'h02; mem[1] = 8'hFF; mem[2] = 8'h04; mem[3] = 8'h00;
    mem[4] = 8'h08; mem[5] = 8'h20; mem[6] = 8'hFF;
    run(4);

    // NTM: complement select only in LATCH.
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h10; mem[2] = 8'hFF; mem[8'h10] = 8'h3C;
    run(2);

    // Undefined opcode as NOP, instruction straddling FE/FF and wrapping to 00.
    clear_mem();
    mem[0] = 8'h5A; mem[1] = 8'h11; mem[2] = 8'h07; mem[3] = 8'hFE;
    mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h33;
    run(4);
    do_reset();

    // Reset asserted at the start of an ADD's LATCH cycle.
    clear_mem();
    mem[0] = 8'h03; mem[1] = 8'h10; mem[2] = 8'hFF; mem[8'h10] = 8'h44;
    step("abort.fetch_op", 8'h00, 13'h0, 8'h00, 0, 8'h0, 8'h0, 0, 1'b0);
    step("abort.fetch_arg", 8'h01, 13'h0, 8'h01, 0, 8'h0, 8'h0, 0, 1'b0);
    check_outs("abort.load_b", 8'h10, S_BLOAD | S_MIEN | S_MSEL, 8'h02);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_outs("abort.in_latch", 8'h00, S_ARST | S_BRST, 8'h00);
    @(posedge clk);
    #1;
    check_outs("abort.held", 8'h00, S_ARST | S_BRST, 8'h00);
    @(negedge clk);
    do_reset();
    run(2);

    // Random programs with occasional resets at instruction boundaries.
    for (int i = 0; i < 256; i++) begin
      int unsigned r;
      r = $urandom_range(0, 15);
      mem[i] = (r < 10) ? optab[r] : 8'($urandom);
    end
    for (int i = 0; i < 300; i++) begin
      run(1);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
